// File: rtl/fifo_sync_buffer.sv
// -----------------------------------------------------------------------------
// fifo_sync_buffer
//   Single-clock FIFO between a bursty byte producer (keypad / UART) and a
//   paced consumer (PISO shifter, FND / LED driver). Storage is a plain
//   register array with no reset, so it maps onto distributed RAM. Status
//   flags and read data are all registered: no combinational path runs from
//   wr_en / rd_en to any output.
//
// Optional feature (macro FIFO_ERR_FLAGS_EN):
//   Adds sticky overflow / underflow flags and an err_clr input.
//
// Handshake:
//   A write is accepted when wr_en=1 and the FIFO is not full, or when it is
//   full and a read is accepted on the same edge. A read is accepted when
//   rd_en=1 and the FIFO is not empty. Data from an accepted read appears on
//   dout, with dout_valid high for exactly one cycle, starting on the edge
//   that accepts the read.
//
// Ports:
//   clk        in   system clock, posedge
//   reset_p    in   asynchronous active-high reset
//   wr_en      in   write request
//   din        in   write data [DATA_W]
//   rd_en      in   read request
//   err_clr    in   clear sticky error flags          (FIFO_ERR_FLAGS_EN only)
//   overflow   out  sticky: write while full, no read (FIFO_ERR_FLAGS_EN only)
//   underflow  out  sticky: read while empty          (FIFO_ERR_FLAGS_EN only)
//   dout       out  registered read data [DATA_W]
//   dout_valid out  one-cycle strobe for newly read dout
//   full       out  count == 2**ADDR_W
//   empty      out  count == 0
//   count      out  stored words [ADDR_W+1]
// -----------------------------------------------------------------------------
module fifo_sync_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // A write into a full FIFO is still legal when a read frees a slot on the
    // same edge.
    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = wr_en & (~r_full | w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is left unreset so it can map to distributed RAM. Stale
    // contents can never be read, because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // When the FIFO is full and both sides are accepted, rd_ptr and
            // wr_ptr are equal. The nonblocking read sees the old word, so the
            // read happens before the write.
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_dout_valid <= w_rd_acc;
            r_count      <= w_count_nxt;
            r_full       <= (w_count_nxt == FULL_CNT);
            r_empty      <= (w_count_nxt == '0);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Set has priority over err_clr on the same edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & r_full & ~w_rd_acc) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en & r_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: doc/fifo_sync_buffer.md
Name: fifo_sync_buffer

Overview:
Single-clock FIFO that buffers data words between a producer (keypad/UART byte source) and a downstream consumer (PISO shifter, FND/LED driver).
- Decouples bursty writes from paced reads.
- Exposes full/empty/count status.
- Registered read data with a one-cycle valid strobe.
- Storage is an internal register array, inferred as distributed RAM.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, pointer width; depth = 2**ADDR_W (16 by default)

Ports:
clk  input  1  system clock; all logic on posedge
reset_p  input  1  asynchronous active-high reset
wr_en  input  1  write request; sampled on posedge clk
din  input  DATA_W  write data, captured with an accepted write
rd_en  input  1  read request; sampled on posedge clk
dout  output  DATA_W  registered read data
dout_valid  output  1  one-cycle pulse, high the cycle dout holds newly read data
full  output  1  high when count == 2**ADDR_W
empty  output  1  high when count == 0
count  output  ADDR_W+1  number of stored words, 0..2**ADDR_W

Behaviour:
- Reset is asynchronous and active-high on reset_p; clock is clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=0, dout_valid=0. Memory contents are not reset; stale data is never observable.
- Write acceptance:
  - wr_acc = wr_en & (~full | rd_acc).
  - On wr_acc: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
- Read acceptance:
  - rd_acc = rd_en & ~empty.
  - On rd_acc: dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1; dout_valid <= 1. Otherwise dout_valid <= 0 and dout holds.
- Read latency: dout/dout_valid update on the same edge that accepts the read, so they are visible the cycle after rd_en is asserted.
- Pointers are ADDR_W bits and wrap modulo 2**ADDR_W with no special case.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
- full and empty are registered, derived from the next count value, and valid in the same cycle as count. No combinational path from wr_en/rd_en to any output.
- Boundary cases:
  - Write when full, no read: ignored. Pointers, count and memory are unchanged.
  - Read when empty: ignored. dout holds and dout_valid=0.
  - Simultaneous read+write when empty: write accepted, read ignored. Next cycle count=1, empty=0, dout_valid=0.
  - Simultaneous read+write when full: both accepted. count stays at 2**ADDR_W, full stays 1, and the oldest word goes to dout.
  - Simultaneous read+write at 0<count<2**ADDR_W: both accepted, count unchanged.
  - Read and write to the same address cannot collide on the same edge except in the full case, where the read returns the old word (read-before-write).
- reset_p asserted mid-operation clears the FIFO immediately (asynchronous). Contents are discarded, and the first post-reset write lands at address 0.
- All sequential assignments are nonblocking.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds ports overflow (output 1), underflow (output 1) and err_clr (input 1).
  - overflow sets sticky on wr_en & full & ~rd_acc.
  - underflow sets sticky on rd_en & empty.
  - Both flags clear on reset_p or on a clock edge with err_clr=1. If set and clear occur on the same edge, set wins.
  - FIFO data behaviour is identical to the undefined case.
- Undefined: these ports and their logic do not exist; illegal requests are silently ignored as described above.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, dout=0, dout_valid=0 throughout.
- Write 0x01..0x10 on 16 consecutive cycles -> count steps 1..16; full=1 after the 16th write. A 17th write of 0xAA is ignored and count stays 16.
- From full, assert rd_en 16 cycles -> dout=0x01..0x10 in order, each with dout_valid=1 one cycle after its rd_en; empty=1 after the last read. A further rd_en gives dout_valid=0 and dout holds 0x10.
- Fill to 3 words, then wr_en+rd_en together for 40 cycles with an incrementing din -> count stays 3, pointers wrap twice, and dout sequence equals the write sequence delayed by 3 words.
- Empty FIFO, wr_en=rd_en=1 with din=0x5A for 1 cycle -> count=1, dout_valid=0. Next cycle rd_en=1 -> dout=0x5A with dout_valid=1.
- Write 5 words, pulse reset_p mid-cycle (asynchronous) -> count=0, empty=1 immediately. Write 0x77 then read -> dout=0x77. With FIFO_ERR_FLAGS_EN, a read on empty sets underflow=1, which holds until err_clr=1.
